// File: rtl/sregn_skid.sv
// Two-entry skid buffer: main register drives o0, skid register absorbs one extra word so
// that i_ready can be registered. Optional synchronous flush when PICO_SKID_FLUSH_EN is defined.
module sregn_skid #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PICO_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i0,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o0,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             i_ready_q;
  logic [width-1:0] main_q, skid_q;
  logic             accept, pop, flush_req;
  logic             load_main, main_from_skid, load_skid;

`ifdef PICO_SKID_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign accept  = i_valid & i_ready_q;
  assign pop     = o_valid & o_ready;
  assign o_valid = (state_q != StEmpty);
  assign i_ready = i_ready_q;
  assign o0      = main_q;
  assign count   = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StOne;
          load_main = 1'b1;
        end
      end
      StOne: begin
        if (accept && !pop) begin
          state_d   = StFull;
          load_skid = 1'b1;
        end else if (pop && !accept) begin
          state_d = StEmpty;
        end else if (pop && accept) begin
          load_main = 1'b1;
        end
      end
      StFull: begin
        if (pop) begin
          state_d        = StOne;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any simultaneous transfer; the incoming word is dropped.
    if (flush_req) begin
      state_d   = StEmpty;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StEmpty;
      i_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_ready_q <= (state_d != StFull);
    end
  end

  // Data registers are deliberately unreset; o0 is only meaningful while o_valid is high.
  always_ff @(posedge clk) begin
    if (load_main) main_q <= main_from_skid ? skid_q : i0;
    if (load_skid) skid_q <= i0;
  end

endmodule

// File: doc/sregn_skid.md
SREGN_SKID -- requirements
Module: sregn_skid

Interface
REQ-001 Parameter: width, default 32, data path width in bits.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: i_valid  input  1  upstream presents valid data on i0.
REQ-005 Port: i_ready  output  1  block can accept data this cycle; registered, with no combinational path from o_ready.
REQ-006 Port: i0  input  width  upstream data.
REQ-007 Port: o_valid  output  1  o0 holds valid data.
REQ-008 Port: o_ready  input  1  downstream accepts o0 this cycle.
REQ-009 Port: o0  output  width  downstream data, driven directly from the main data register.
REQ-010 Port: count  output  2  occupancy 0..2, equal to the state encoding.

Function
REQ-011 Definitions: accept = i_valid & i_ready; pop = o_valid & o_ready.
REQ-012 Storage is a main register (drives o0) plus one skid register, each width bits.
REQ-013 State machine states: EMPTY (count=0), ONE (count=1), FULL (count=2); a count value of 3 never occurs.
REQ-014 EMPTY: accept -> ONE, main<=i0; otherwise the state is held.
REQ-015 ONE with accept & !pop -> FULL, skid<=i0, main unchanged.
REQ-016 ONE with pop & !accept -> EMPTY.
REQ-017 ONE with pop & accept -> stays in ONE, main<=i0 in the same edge.
REQ-018 ONE with neither accept nor pop -> held, main unchanged.
REQ-019 FULL: i_ready=0; pop -> ONE, main<=skid; no pop -> held.
REQ-020 o_valid = (state != EMPTY).
REQ-021 i_ready = (next state != FULL), registered; i_ready is 1 in EMPTY and ONE.
REQ-022 Latency: i0 accepted at edge N appears on o0 with o_valid=1 after edge N when the block was EMPTY, or when it was ONE with a pop at edge N.
REQ-023 Throughput: with o_ready held 1, one word per cycle is sustained with no bubbles.
REQ-024 Ordering is strict FIFO; no word is dropped or duplicated under any i_valid/o_ready pattern.
REQ-025 o0 and o_valid are held stable while o_valid=1 and o_ready=0.
REQ-026 i_valid while i_ready=0 has no effect.

Reset
REQ-027 While reset=0: state=EMPTY, count=0, o_valid=0, i_ready=0.
REQ-028 i_ready rises to 1 on the first rising clk edge after reset deasserts.
REQ-029 Main and skid data registers are not reset; o0 is undefined until the first load and is meaningful only while o_valid=1.
REQ-030 Reset asserted mid-transfer discards all held words immediately (asynchronous); no word held before reset is presented after reset.

Configuration
REQ-031 Macro PICO_SKID_FLUSH_EN defined: adds input port flush (1 bit, synchronous, active-high).
REQ-032 With flush=1 at a rising edge: next state=EMPTY, count=0, o_valid=0 and i_ready=1 after that edge.
REQ-033 flush has priority over a simultaneous accept or pop; the incoming word in that cycle is dropped and the pop is not counted as a transfer.
REQ-034 Macro undefined: no flush port and no flush logic; behaviour is exactly REQ-011..REQ-030.

Verification
REQ-035 Reset release, then i_valid=1 with i0=0x11 at the first edge where i_ready=1, o_ready=1 -> next cycle o_valid=1, o0=0x11, count=1.
REQ-036 Stream 0x01..0x08, i_valid and o_ready held 1 -> o0 shows 0x01..0x08 on 8 consecutive cycles, count stays 1, i_ready stays 1.
REQ-037 o_ready=0, push 0xA0 then 0xA1 -> count=2, i_ready=0, o0=0xA0; 0xA2 offered is not accepted; o_ready=1 -> o0 shows 0xA0, 0xA1, 0xA2 in order.
REQ-038 Random i_valid/o_ready at 50% each, 1000 words -> output sequence equals input sequence and count never exceeds 2.
REQ-039 FULL with 0xB0/0xB1 held, reset pulsed low for half a cycle -> o_valid=0 and count=0 immediately; after release, 0xB0/0xB1 never appear on o0.
REQ-040 With PICO_SKID_FLUSH_EN defined, FULL, flush=1 together with i_valid=1, i0=0xC5 -> next cycle count=0, o_valid=0, i_ready=1, and 0xC5 is never output.
